instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the immediate generator: packs decoded fields (format, opcode, registers, funct, immediate) into 32-bit RV32I instruction words.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by the program-load path and by self-checking benches, which round-trip encoded words through imm_gen.
- Sequential: valid/ready input, one-stage pack pipeline, load FSM, address counter, sticky error.

Parameters:
- ADDR_W, 32, width of mem_addr (byte address).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- DEPTH, 256, maximum words per load session (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a load session (sampled in IDLE only).
- in_valid  input  1  field set present.
- in_ready  output  1  field set accepted when in_valid & in_ready.
- fmt  input  2  0=R, 1=I, 2=S, 3=SB.
- opcode  input  7  placed at instr[6:0].
- rd  input  5  placed at [11:7] (R, I only).
- rs1  input  5  placed at [19:15] (R, I, S, SB).
- rs2  input  5  placed at [24:20] (R, S, SB).
- funct3  input  3  placed at [14:12].
- funct7  input  7  placed at [31:25] (R only).
- imm  input  32  signed immediate. For SB it is the halfword offset b (byte offset >> 1), matching imm_gen output.
- last  input  1  marks the final field set of the session.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  byte address of the write.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky range error, cleared by start or rst.
- count  output  $clog2(DEPTH+1)  words written this session.

Behaviour:
- Reset values: state IDLE; in_ready, mem_we, busy, done, err all 0; mem_addr BASE_ADDR; mem_wdata 0; count 0.
  - rst mid-session drops any pending write; mem_we is 0 on the cycle after rst.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start. On entry: count=0, word index=0, err=0.
  - LOAD -> DONE on acceptance of a word with last=1.
  - LOAD -> DONE on acceptance of the word at index DEPTH-1 (capacity reached; last is ignored).
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE.
  - start is ignored in LOAD and DONE.
- in_ready = (state==LOAD).
- Latency: fields accepted at cycle N appear at cycle N+1 as mem_we=1, with mem_wdata=packed word and mem_addr=BASE_ADDR+4*index.
  - index and count increment at N+1.
  - Back-to-back acceptance gives one write per cycle.
  - The write for the final word occurs in the DONE cycle.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - SB, with b=imm[11:0]: instr[31]=b[11], [7]=b[10], [30:25]=b[9:4], [11:8]=b[3:0].
  - Unused fields are ignored.
- Range: imm is legal when -2048 <= imm <= 2047 for I, S, SB. imm is ignored for R.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined: an out-of-range imm sets err (sticky). That word is not written, and mem_we stays 0 at N+1. index and count do not advance. The FSM still honours last and the capacity rule.
- Not defined: no check; imm is truncated to imm[11:0], and err is tied to 0.

Decomposition:
- Shared package holds:
  - format enum FMT_R/FMT_I/FMT_S/FMT_SB;
  - state enum;
  - opcode constants OP_IMM=7'b0010011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, OP_REG=7'b0110011;
  - IMM_MIN=-2048, IMM_MAX=2047.
- One combinational sub-module, instr_pack: fields in -> 32-bit word plus range_ok out.
- The FSM, counter and output register stay in the top.

Test Plan:
- start, then I-type {opcode OP_IMM, rd0, rs1 0, funct3 0, imm 7, last 0} -> next cycle mem_we=1, addr 0x0, wdata 0x00700013, count=1.
- Following I-type imm -505 -> wdata 0xE0700013 at addr 0x4.
- Then S-type imm 3 with opcode OP_STORE -> wdata 0x000001A3 at addr 0x8.
- SB opcode OP_BRANCH with imm 1, 16, 1024, -2048 -> wdata 0x00000163, 0x02000063, 0x000000E3, 0x80000063; imm_gen round-trips each to the same b value.
- R-type funct7 7'b0000001, opcode OP_REG, all regs 0, last=1 -> wdata 0x02000033; done pulses one cycle; busy falls; in_ready=0; a new start is required before further acceptance.
- RANGE_CHECK_EN: I-type imm 2048 -> err=1, no mem_we, count unchanged. The next legal word is written at the unchanged address. Without the macro: wdata 0x80000013, err=0.
- DEPTH=4: four accepts without last -> writes at 0x0..0xC, done after the fourth, in_ready low. Assert rst during a back-to-back stream -> mem_we 0 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and constants for the RV32I instruction encoder / loader.
// Optional feature: RANGE_CHECK_EN enables immediate range checking.
package instr_encoder_loader_pkg;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_I  = 2'd1,
        FMT_S  = 2'd2,
        FMT_SB = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int IMM_MIN = -2048;
    localparam int IMM_MAX = 2047;

    // True when the signed immediate fits the 12-bit encodable range.
    function automatic logic imm_in_range(input logic [31:0] imm);
        return ($signed(imm) >= IMM_MIN) && ($signed(imm) <= IMM_MAX);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational field packer: decoded RV32I fields -> 32-bit instruction word.
// range_ok_o reports whether the immediate is encodable for the selected format.
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_ok_o
);

    logic [11:0] imm12;

    assign imm12 = imm_i[11:0];

    // SB immediate is the halfword offset, so bit 0 of it lands at instr[8].
    always_comb begin
        word_o     = 32'h0;
        range_ok_o = 1'b1;
        case (fmt_e'(fmt_i))
            FMT_R: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                word_o     = {imm12, rs1_i, funct3_i, rd_i, opcode_i};
                range_ok_o = imm_in_range(imm_i);
            end
            FMT_S: begin
                word_o     = {imm12[11:5], rs2_i, rs1_i, funct3_i, imm12[4:0], opcode_i};
                range_ok_o = imm_in_range(imm_i);
            end
            FMT_SB: begin
                word_o     = {imm12[11], imm12[9:4], rs2_i, rs1_i, funct3_i,
                              imm12[3:0], imm12[10], opcode_i};
                range_ok_o = imm_in_range(imm_i);
            end
            default: begin
                word_o     = 32'h0;
                range_ok_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs decoded field sets into RV32I words and streams them to instruction memory.
// Define RANGE_CHECK_EN to reject out-of-range immediates and flag a sticky err.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         DEPTH     = 256,
    localparam int unsigned        CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]         packed_word;
    logic                range_ok;
    logic                accept;
    logic                write_ok;

    instr_pack u_pack (
        .fmt_i      (fmt),
        .opcode_i   (opcode),
        .rd_i       (rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .imm_i      (imm),
        .word_o     (packed_word),
        .range_ok_o (range_ok)
    );

`ifdef RANGE_CHECK_EN
    assign write_ok = range_ok;
`else
    logic unused_range_ok;
    assign unused_range_ok = range_ok;
    assign write_ok        = 1'b1;
`endif

    assign accept = in_valid && in_ready_q;

    // Next-state, write strobe and counter; the word index is the write count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (write_ok) begin
                        we_d    = 1'b1;
                        wdata_d = packed_word;
                        addr_d  = BASE_ADDR + (ADDR_W'(cnt_q) << 2);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                    if (last || (cnt_q == LAST_IDX)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d == ST_LOAD);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed table, corner sequences, and random
// traffic against a session-level model, on a default instance and a DEPTH=4 one.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int unsigned BIG_D    = 256;
    localparam int unsigned SMALL_D  = 4;
    localparam int unsigned BIG_CW   = $clog2(BIG_D + 1);
    localparam int unsigned SMALL_CW = $clog2(SMALL_D + 1);
`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, last;
    logic [1:0]  fmt;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;

    logic                b_ready, b_we, b_busy, b_done, b_err;
    logic [31:0]         b_addr, b_wdata;
    logic [BIG_CW-1:0]   b_count;
    logic                s_ready, s_we, s_busy, s_done, s_err;
    logic [31:0]         s_addr, s_wdata;
    logic [SMALL_CW-1:0] s_count;

    instr_encoder_loader u_big (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .last(last), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
    );

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(SMALL_D)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .last(last), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
    );

    int total = 0;
    int bad   = 0;

    // Session view of one loader: loading, done pulse, words written, last write.
    typedef struct {
        bit          loading;
        bit          done_now;
        bit          err;
        int          words;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mdl_t;

    mdl_t mb, ms;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          last;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction word built from the field rules with shifts and masks.
    function automatic logic [31:0] ref_pack();
        logic [31:0] b, w, base;
        b    = imm & 32'hFFF;
        base = (32'(rs1) << 15) | (32'(funct3) << 12) | 32'(opcode);
        case (fmt)
            2'd0: w = (32'(funct7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            2'd1: w = (b << 20) | base | (32'(rd) << 7);
            2'd2: w = ((b >> 5) << 25) | (32'(rs2) << 20) | base | ((b & 32'h1F) << 7);
            default: w = (((b >> 11) & 32'h1) << 31) | (((b >> 4) & 32'h3F) << 25)
                         | (32'(rs2) << 20) | base | ((b & 32'hF) << 8)
                         | (((b >> 10) & 32'h1) << 7);
        endcase
        return w;
    endfunction

    function automatic bit ref_ok();
        int s;
        s = int'($signed(imm));
        return (fmt == 2'd0) || ((s >= -2048) && (s <= 2047));
    endfunction

    // Branch offset as imm_gen would recover it from the word.
    function automatic int sb_decode(input logic [31:0] w);
        logic [11:0] b;
        b = {w[31], w[7], w[30:25], w[11:8]};
        return int'($signed(b));
    endfunction

    function automatic int sext12(input logic [31:0] v);
        logic [11:0] t;
        t = v[11:0];
        return int'($signed(t));
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input int depth, input logic [31:0] w,
                                   input bit ok);
        bit cap;
        if (rst) begin
            m = '{default: 0};
            return m;
        end
        m.we = 1'b0;
        if (m.done_now) begin
            m.done_now = 1'b0;
        end else if (!m.loading) begin
            if (start) begin
                m.loading = 1'b1;
                m.words   = 0;
                m.err     = 1'b0;
            end
        end else if (in_valid) begin
            cap = (m.words == depth - 1);
            if (ok || !RC) begin
                m.we    = 1'b1;
                m.wdata = w;
                m.addr  = 32'(4 * m.words);
                m.words++;
            end else begin
                m.err = 1'b1;
            end
            if (last || cap) begin
                m.loading  = 1'b0;
                m.done_now = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic check_all();
        chk("big.in_ready", 32'(b_ready), 32'(mb.loading));
        chk("big.busy",     32'(b_busy),  32'(mb.loading));
        chk("big.done",     32'(b_done),  32'(mb.done_now));
        chk("big.err",      32'(b_err),   32'(mb.err));
        chk("big.count",    32'(b_count), 32'(mb.words));
        chk("big.we",       32'(b_we),    32'(mb.we));
        chk("big.addr",     b_addr,       mb.addr);
        chk("big.wdata",    b_wdata,      mb.wdata);
        chk("small.in_ready", 32'(s_ready), 32'(ms.loading));
        chk("small.busy",     32'(s_busy),  32'(ms.loading));
        chk("small.done",     32'(s_done),  32'(ms.done_now));
        chk("small.err",      32'(s_err),   32'(ms.err));
        chk("small.count",    32'(s_count), 32'(ms.words));
        chk("small.we",       32'(s_we),    32'(ms.we));
        chk("small.addr",     s_addr,       ms.addr);
        chk("small.wdata",    s_wdata,      ms.wdata);
    endtask

    task automatic tick();
        logic [31:0] w;
        bit          ok;
        @(posedge clk);
        w  = ref_pack();
        ok = ref_ok();
        mb = mstep(mb, BIG_D, w, ok);
        ms = mstep(ms, SMALL_D, w, ok);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm; last = v.last;
    endtask

    task automatic set_i(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [31:0] im,
                         input bit l);
        fmt = 2'd1; opcode = OP_IMM; rd = r_d; rs1 = r_s1; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = im; last = l;
    endtask

    task automatic rand_fields();
        fmt = 2'($urandom_range(3)); opcode = 7'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
        funct7 = 7'($urandom); last = ($urandom_range(9) == 0);
        case ($urandom_range(3))
            0: imm = 32'($urandom_range(4095)) - 32'd2048;
            1: begin
                case ($urandom_range(3))
                    0: imm = 32'hFFFF_F800;
                    1: imm = 32'h0000_07FF;
                    2: imm = 32'hFFFF_F7FF;
                    default: imm = 32'h0000_0800;
                endcase
            end
            2: imm = $urandom;
            default: imm = 32'($urandom_range(255));
        endcase
    endtask

    initial begin
        tbl[0] = '{2'd1, OP_IMM,    5'd0,  5'd0, 5'd9, 3'd0, 7'h55, 32'd7,          1'b0, 32'h0070_0013};
        tbl[1] = '{2'd1, OP_IMM,    5'd0,  5'd0, 5'd9, 3'd0, 7'h55, 32'hFFFF_FE07,  1'b0, 32'hE070_0013};
        tbl[2] = '{2'd2, OP_STORE,  5'd31, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,          1'b0, 32'h0000_01A3};
        tbl[3] = '{2'd3, OP_BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'd1,          1'b0, 32'h0000_0163};
        tbl[4] = '{2'd3, OP_BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'd16,         1'b0, 32'h0200_0063};
        tbl[5] = '{2'd3, OP_BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'd1024,       1'b0, 32'h0000_00E3};
        tbl[6] = '{2'd3, OP_BRANCH, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_F800,  1'b0, 32'h8000_0063};
        tbl[7] = '{2'd0, OP_REG,    5'd0,  5'd0, 5'd0, 3'd0, 7'h01, 32'hDEAD_BEEF,  1'b1, 32'h0200_0033};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        set_i(5'd0, 5'd0, 32'd0, 1'b0);
        tick();
        tick();
        chk("reset.we",    32'(b_we), 32'h0);
        chk("reset.addr",  b_addr, 32'h0);
        chk("reset.wdata", b_wdata, 32'h0);
        chk("reset.count", 32'(b_count), 32'h0);
        rst = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.in_ready", 32'(b_ready), 32'h1);

        // Back-to-back directed words; DEPTH=4 instance stops after four.
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("tbl%0d.wdata", i), b_wdata, tbl[i].exp);
            chk($sformatf("tbl%0d.addr", i),  b_addr, 32'(4 * i));
            chk($sformatf("tbl%0d.count", i), 32'(b_count), 32'(i + 1));
            if (tbl[i].fmt == 2'd3)
                chk($sformatf("tbl%0d.roundtrip", i), 32'(sb_decode(b_wdata)), 32'(sext12(tbl[i].imm)));
            if (i < 4) begin
                chk($sformatf("small%0d.addr", i), s_addr, 32'(4 * i));
                chk($sformatf("small%0d.we", i), 32'(s_we), 32'h1);
            end
            if (i == 3) begin
                chk("small.cap_done", 32'(s_done), 32'h1);
                chk("small.cap_ready", 32'(s_ready), 32'h0);
            end
        end
        chk("last.done",  32'(b_done), 32'h1);
        chk("last.busy",  32'(b_busy), 32'h0);
        chk("last.ready", 32'(b_ready), 32'h0);

        // start during DONE is ignored; no acceptance without a fresh start.
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("done.pulse_end", 32'(b_done), 32'h0);
        set_i(5'd3, 5'd4, 32'd9, 1'b0);
        in_valid = 1'b1;
        tick();
        chk("idle.no_we", 32'(b_we), 32'h0);
        chk("idle.no_ready", 32'(b_ready), 32'h0);
        in_valid = 1'b0;

        // Immediate just above the encodable range.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_i(5'd0, 5'd0, 32'd2048, 1'b0);
        in_valid = 1'b1;
        tick();
`ifdef RANGE_CHECK_EN
        chk("range.err", 32'(b_err), 32'h1);
        chk("range.we",  32'(b_we), 32'h0);
        chk("range.count", 32'(b_count), 32'h0);
`else
        chk("range.wdata", b_wdata, 32'h8000_0013);
        chk("range.err", 32'(b_err), 32'h0);
`endif
        set_i(5'd1, 5'd2, 32'd5, 1'b0);
        tick();
        chk("range.next_wdata", b_wdata, 32'h0051_0093);
`ifdef RANGE_CHECK_EN
        chk("range.next_addr", b_addr, 32'h0);
        chk("range.sticky", 32'(b_err), 32'h1);
`else
        chk("range.next_addr", b_addr, 32'h4);
`endif
        fmt = 2'd0; opcode = OP_REG; last = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a back-to-back stream.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.err", 32'(b_err), 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            last = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        chk("rst.we",    32'(b_we), 32'h0);
        chk("rst.busy",  32'(b_busy), 32'h0);
        chk("rst.count", 32'(b_count), 32'h0);
        chk("rst.addr",  b_addr, 32'h0);
        chk("rst.wdata", b_wdata, 32'h0);
        chk("rst.ready", 32'(b_ready), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(199) == 0);
            start    = ($urandom_range(3) == 0);
            in_valid = ($urandom_range(3) != 0);
            rand_fields();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
